stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline control and shared-memory arbiter for the five-stage RISC-V core. Produces the 6-bit `stall` vector consumed by PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the `flush` strobe for taken branches. Arbitrates the single external memory port between instruction fetch (IF) and load/store (MEM), running a request/ready handshake on that port. It is the source of the stall protocol that the pipeline registers obey: `stall[k]` freezes stage k, and `stall[k] && !stall[k+1]` makes the downstream register inject a bubble.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data word width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch wants a word at `if_addr`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched instruction, valid with `if_valid`.
- `if_valid`  out  1  one-cycle pulse: fetch complete.
- `mem_req`  in  1  MEM stage access request.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  ADDR_W  load/store address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_be`  in  4  byte enables.
- `mem_rdata`  out  DATA_W  load data, valid with `mem_valid`.
- `mem_valid`  out  1  one-cycle pulse: load/store complete.
- `id_stallreq`  in  1  load-use hazard from ID, combinational, single cycle.
- `ex_branch_flag`  in  1  EX resolved a taken branch/jump.
- `flush`  out  1  kill IF/ID contents this cycle.
- `stall`  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=reserved (always 0).
- `ram_req`, `ram_we`  out  1  external port request / write.
- `ram_addr`  out  ADDR_W; `ram_wdata`  out  DATA_W; `ram_be`  out  4.
- `ram_ready`  in  1  external port: access done this cycle.
- `ram_rdata`  in  DATA_W  read data, valid when `ram_ready`.

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY, IF_DROP.
- IDLE: if `mem_req && !mem_valid` -> MEM_BUSY, latch `mem_*` onto `ram_*`, `ram_req`<=1. Else if `if_req && !if_valid` -> IF_BUSY, latch `if_addr`, `ram_we`<=0, `ram_be`<=4'hF. MEM has priority.
- IF_BUSY / MEM_BUSY: hold `ram_*` stable. On `ram_ready`: `ram_req`<=0, capture `ram_rdata` into `if_rdata`/`mem_rdata`, pulse matching `*_valid` next cycle, -> IDLE.
- `ex_branch_flag` in IF_BUSY without `ram_ready` -> IF_DROP. IF_DROP waits for `ram_ready`, discards data (no `if_valid`), -> IDLE. A branch in the `ram_ready` cycle suppresses that `if_valid`.
- `flush` = `ex_branch_flag` (combinational, same cycle).
- `stall` (combinational, first match wins):
  - `mem_req && !mem_valid` -> 6'b011111.
  - `id_stallreq` -> 6'b000111.
  - `if_req && !if_valid` -> 6'b000011.
  - otherwise 6'b000000.
- MEM stores: `mem_rdata` is undefined and `mem_valid` pulses on completion.
- Reset: state IDLE; `ram_req`, `ram_we`, `if_valid`, `mem_valid` = 0; `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata` = 0; `ram_be` = 0. `stall` = 0 while `rst` is high. Reset mid-transfer abandons it; a late `ram_ready` after reset is ignored in IDLE.

## Timing
- Request seen in IDLE at cycle N -> `ram_req` high from N+1.
- `ram_ready` sampled high at cycle M -> `*_valid` and data at M+1, FSM in IDLE at M+1.
- In the `*_valid` cycle, IDLE does not accept the same requester again. Next issue from IDLE is at M+2.
- Minimum access: 3 cycles request-to-valid (ready at N+1, valid at N+2).
- Simultaneous `if_req` and `mem_req` in IDLE: MEM served first, fetch issued after `mem_valid`. Stall stays 6'b011111 until `mem_valid`, then 6'b000011 until `if_valid`.
- `ram_req` never deasserts before `ram_ready`. Address, data and byte enables are constant while `ram_req` is high.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x100, `ram_ready` at N+1 with rdata 0x00000013. Required: `ram_req` at N+1; `if_valid`, `if_rdata`=0x13 at N+2; `stall`=000011 through N+1, 000000 at N+2.
- Load with 3-cycle memory: `mem_req` at N, addr 0x2000, `ram_ready` at N+3. Required: `stall`=011111 N..N+3; `mem_valid` at N+4; no reissue at N+4.
- Collision: `if_req` and `mem_req` both set in IDLE. Required: first `ram_addr`=mem_addr, then if_addr; stall sequence 011111 -> 000011 -> 000000.
- Load-use: `id_stallreq`=1 for one cycle with no memory activity. Required: `stall`=000111 exactly that cycle.
- Branch during fetch: `ex_branch_flag` at N+1 while IF_BUSY, `ram_ready` at N+3. Required: `flush`=1 at N+1, no `if_valid`, IDLE at N+4.
- Reset mid-MEM_BUSY. Required: all outputs 0 the next cycle, a subsequent `ram_ready` produces no `*_valid`.

Source files
------------

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush generation and IF/MEM arbitration of the single external
// memory port (request held until ram_ready; MEM wins ties).
module stall_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    input  logic              id_stallreq,
    input  logic              ex_branch_flag,
    output logic              flush,
    output logic [5:0]        stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_MEM_BUSY,
        S_IF_DROP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_ram_req;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [3:0]        r_ram_be;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_mem_valid;

    logic       w_mem_pend;
    logic       w_if_pend;
    logic       w_issue_mem;
    logic       w_issue_if;
    logic       w_done;
    logic       w_if_deliver;
    logic       w_mem_deliver;
    logic [5:0] w_stall;

    // A requester whose *_valid is pulsing this cycle is already served.
    assign w_mem_pend = mem_req && !r_mem_valid;
    assign w_if_pend  = if_req  && !r_if_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_issue_mem   = 1'b0;
        w_issue_if    = 1'b0;
        w_done        = 1'b0;
        w_if_deliver  = 1'b0;
        w_mem_deliver = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_pend) begin
                    w_state_nxt = S_MEM_BUSY;
                    w_issue_mem = 1'b1;
                end else if (w_if_pend) begin
                    w_state_nxt = S_IF_BUSY;
                    w_issue_if  = 1'b1;
                end
            end
            S_IF_BUSY: begin
                if (ram_ready) begin
                    w_state_nxt  = S_IDLE;
                    w_done       = 1'b1;
                    w_if_deliver = !ex_branch_flag;
                end else if (ex_branch_flag) begin
                    w_state_nxt = S_IF_DROP;
                end
            end
            S_MEM_BUSY: begin
                if (ram_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_done        = 1'b1;
                    w_mem_deliver = 1'b1;
                end
            end
            S_IF_DROP: begin
                if (ram_ready) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_be    <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_mem_rdata <= '0;
            r_mem_valid <= 1'b0;
        end else begin
            r_if_valid  <= w_if_deliver;
            r_mem_valid <= w_mem_deliver;
            if (w_issue_mem) begin
                r_ram_req   <= 1'b1;
                r_ram_we    <= mem_we;
                r_ram_addr  <= mem_addr;
                r_ram_wdata <= mem_wdata;
                r_ram_be    <= mem_be;
            end else if (w_issue_if) begin
                r_ram_req  <= 1'b1;
                r_ram_we   <= 1'b0;
                r_ram_addr <= if_addr;
                r_ram_be   <= '1;
            end else if (w_done) begin
                r_ram_req <= 1'b0;
            end
            if (w_if_deliver) begin
                r_if_rdata <= ram_rdata;
            end
            if (w_mem_deliver) begin
                r_mem_rdata <= ram_rdata;
            end
        end
    end

    always_comb begin
        w_stall = 6'b000000;
        if (rst) begin
            w_stall = 6'b000000;
        end else if (w_mem_pend) begin
            w_stall = 6'b011111;
        end else if (id_stallreq) begin
            w_stall = 6'b000111;
        end else if (w_if_pend) begin
            w_stall = 6'b000011;
        end
    end

    assign stall     = w_stall;
    assign flush     = ex_branch_flag;
    assign ram_req   = r_ram_req;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_be    = r_ram_be;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign mem_rdata = r_mem_rdata;
    assign mem_valid = r_mem_valid;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed and random checks of stall_ctrl against a transaction-level model.
module tb_stall_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          id_stallreq;
    logic          ex_branch_flag;
    logic          flush;
    logic [5:0]    stall;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [3:0]    ram_be;
    logic          ram_ready;
    logic [DW-1:0] ram_rdata;

    stall_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .id_stallreq(id_stallreq), .ex_branch_flag(ex_branch_flag),
        .flush(flush), .stall(stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_ready(ram_ready), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Transaction-level model: one outstanding access, who it belongs to,
    // whether a branch cancelled it, and the values the DUT should present.
    bit            m_busy;
    bit            m_fetch;
    bit            m_drop;
    bit            m_known;
    logic          e_ram_req;
    logic          e_ram_we;
    logic [AW-1:0] e_ram_addr;
    logic [DW-1:0] e_ram_wdata;
    logic [3:0]    e_ram_be;
    logic          e_if_valid;
    logic          e_mem_valid;
    logic [DW-1:0] e_if_rdata;
    logic [DW-1:0] e_mem_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_stall();
        if (rst) return 6'b000000;
        if (mem_req && !e_mem_valid) return 6'b011111;
        if (id_stallreq) return 6'b000111;
        if (if_req && !e_if_valid) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic model_step();
        logic nif;
        logic nmem;
        nif  = 1'b0;
        nmem = 1'b0;
        if (rst) begin
            m_busy = 0; m_fetch = 0; m_drop = 0; m_known = 1;
            e_ram_req = 0; e_ram_we = 0; e_ram_addr = '0; e_ram_wdata = '0; e_ram_be = '0;
            e_if_valid = 0; e_mem_valid = 0; e_if_rdata = '0; e_mem_rdata = '0;
        end else begin
            if (!m_busy) begin
                if (mem_req && !e_mem_valid) begin
                    m_busy = 1; m_fetch = 0; m_drop = 0;
                    e_ram_req = 1; e_ram_we = mem_we; e_ram_addr = mem_addr;
                    e_ram_wdata = mem_wdata; e_ram_be = mem_be;
                end else if (if_req && !e_if_valid) begin
                    m_busy = 1; m_fetch = 1; m_drop = 0;
                    e_ram_req = 1; e_ram_we = 0; e_ram_addr = if_addr; e_ram_be = 4'hF;
                end
            end else if (ram_ready) begin
                m_busy = 0;
                e_ram_req = 0;
                if (!m_fetch) begin
                    nmem = 1'b1;
                    e_mem_rdata = ram_rdata;
                    m_known = !e_ram_we;
                end else if (!m_drop && !ex_branch_flag) begin
                    nif = 1'b1;
                    e_if_rdata = ram_rdata;
                end
            end else if (m_fetch && ex_branch_flag) begin
                m_drop = 1;
            end
            e_if_valid  = nif;
            e_mem_valid = nmem;
        end
    endtask

    task automatic check_all();
        chk("stall", {26'd0, stall}, {26'd0, exp_stall()});
        chk("flush", {31'd0, flush}, {31'd0, ex_branch_flag});
        chk("ram_req", {31'd0, ram_req}, {31'd0, e_ram_req});
        chk("if_valid", {31'd0, if_valid}, {31'd0, e_if_valid});
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, e_mem_valid});
        chk("if_rdata", if_rdata, e_if_rdata);
        if (m_known) chk("mem_rdata", mem_rdata, e_mem_rdata);
        if (e_ram_req) begin
            chk("ram_addr", ram_addr, e_ram_addr);
            chk("ram_we", {31'd0, ram_we}, {31'd0, e_ram_we});
            chk("ram_be", {28'd0, ram_be}, {28'd0, e_ram_be});
            if (e_ram_we) chk("ram_wdata", ram_wdata, e_ram_wdata);
        end
    endtask

    // Settle current inputs, compare, then advance model and DUT one clock.
    task automatic cyc();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
        mem_wdata = '0; mem_be = '0; id_stallreq = 0; ex_branch_flag = 0;
        ram_ready = 0; ram_rdata = '0;
    endtask

    initial begin
        idle_in();
        rst = 1;
        model_step();
        @(posedge clk);
        #1;
        cyc();
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_be", {28'd0, ram_be}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_valids", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("rst_stall", {26'd0, stall}, 32'd0);
        rst = 0;
        cyc();

        // Fetch only, zero-wait memory
        if_req = 1; if_addr = 32'h100;
        #1 chk("fetch_stall_N", {26'd0, stall}, 32'b000011);
        cyc();
        chk("fetch_ram_req_N1", {31'd0, ram_req}, 32'd1);
        chk("fetch_addr", ram_addr, 32'h100);
        ram_ready = 1; ram_rdata = 32'h00000013;
        #1 chk("fetch_stall_N1", {26'd0, stall}, 32'b000011);
        cyc();
        chk("fetch_valid_N2", {31'd0, if_valid}, 32'd1);
        chk("fetch_rdata_N2", if_rdata, 32'h13);
        ram_ready = 0; ram_rdata = '0;
        #1 chk("fetch_stall_N2", {26'd0, stall}, 32'd0);
        cyc();
        if_req = 0;
        cyc();

        // Load, memory ready three cycles after the request
        mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("load_stall", {26'd0, stall}, 32'b011111);
            cyc();
        end
        ram_ready = 1; ram_rdata = 32'hCAFE0001;
        #1 chk("load_stall_N3", {26'd0, stall}, 32'b011111);
        cyc();
        chk("load_valid_N4", {31'd0, mem_valid}, 32'd1);
        chk("load_rdata_N4", mem_rdata, 32'hCAFE0001);
        ram_ready = 0;
        #1 chk("load_stall_N4", {26'd0, stall}, 32'd0);
        cyc();
        chk("load_no_reissue", {31'd0, ram_req}, 32'd0);
        mem_req = 0;
        cyc();

        // Collision: store served first, then fetch
        if_req = 1; if_addr = 32'h300;
        mem_req = 1; mem_we = 1; mem_addr = 32'h400; mem_wdata = 32'h55AA55AA; mem_be = 4'b0011;
        #1 chk("coll_stall_mem", {26'd0, stall}, 32'b011111);
        cyc();
        chk("coll_first_addr", ram_addr, 32'h400);
        chk("coll_first_we", {31'd0, ram_we}, 32'd1);
        ram_ready = 1;
        cyc();
        chk("coll_mem_valid", {31'd0, mem_valid}, 32'd1);
        mem_req = 0; ram_ready = 0;
        #1 chk("coll_stall_if", {26'd0, stall}, 32'b000011);
        cyc();
        chk("coll_second_req", {31'd0, ram_req}, 32'd1);
        chk("coll_second_addr", ram_addr, 32'h300);
        chk("coll_second_be", {28'd0, ram_be}, 32'hF);
        ram_ready = 1; ram_rdata = 32'h00100093;
        cyc();
        chk("coll_if_valid", {31'd0, if_valid}, 32'd1);
        chk("coll_if_rdata", if_rdata, 32'h00100093);
        ram_ready = 0;
        #1 chk("coll_stall_done", {26'd0, stall}, 32'd0);
        cyc();
        if_req = 0;
        cyc();

        // Load-use bubble
        id_stallreq = 1;
        #1 chk("loaduse_stall", {26'd0, stall}, 32'b000111);
        cyc();
        id_stallreq = 0;
        #1 chk("loaduse_after", {26'd0, stall}, 32'd0);
        cyc();

        // Branch while fetch outstanding: data discarded
        if_req = 1; if_addr = 32'h500;
        cyc();
        chk("br_ram_req", {31'd0, ram_req}, 32'd1);
        ex_branch_flag = 1; if_req = 0;
        #1 chk("br_flush", {31'd0, flush}, 32'd1);
        cyc();
        ex_branch_flag = 0;
        cyc();
        ram_ready = 1; ram_rdata = 32'h00000BAD;
        cyc();
        chk("br_no_valid", {31'd0, if_valid}, 32'd0);
        chk("br_req_low", {31'd0, ram_req}, 32'd0);
        ram_ready = 0; if_req = 1; if_addr = 32'h600;
        cyc();
        chk("br_idle_reissue", {31'd0, ram_req}, 32'd1);
        chk("br_idle_addr", ram_addr, 32'h600);
        ram_ready = 1; ram_rdata = 32'h13;
        cyc();
        chk("br_refetch_valid", {31'd0, if_valid}, 32'd1);
        if_req = 0; ram_ready = 0;
        cyc();

        // Branch in the same cycle as ram_ready
        if_req = 1; if_addr = 32'h700;
        cyc();
        ram_ready = 1; ram_rdata = 32'h12345678; ex_branch_flag = 1; if_req = 0;
        cyc();
        chk("br_ready_no_valid", {31'd0, if_valid}, 32'd0);
        ram_ready = 0; ex_branch_flag = 0;
        cyc();

        // Reset in the middle of a load
        mem_req = 1; mem_we = 0; mem_addr = 32'h800; mem_be = 4'hF;
        cyc();
        chk("rstmid_busy", {31'd0, ram_req}, 32'd1);
        rst = 1;
        #1 chk("rstmid_stall", {26'd0, stall}, 32'd0);
        cyc();
        chk("rstmid_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rstmid_ram_addr", ram_addr, 32'd0);
        chk("rstmid_ram_be", {28'd0, ram_be}, 32'd0);
        chk("rstmid_valids", {30'd0, if_valid, mem_valid}, 32'd0);
        rst = 0; mem_req = 0; ram_ready = 1; ram_rdata = 32'hFFFF0000;
        cyc();
        chk("rstmid_late_ready", {30'd0, if_valid, mem_valid}, 32'd0);
        chk("rstmid_no_req", {31'd0, ram_req}, 32'd0);
        ram_ready = 0;
        cyc();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(199) == 0);
            if_req         = ($urandom_range(99) < 50);
            if_addr        = {$urandom} & 32'hFFFF_FFFC;
            mem_req        = ($urandom_range(99) < 30);
            mem_we         = $urandom_range(1);
            mem_addr       = $urandom;
            mem_wdata      = $urandom;
            mem_be         = 4'($urandom_range(15));
            id_stallreq    = ($urandom_range(7) == 0);
            ex_branch_flag = ($urandom_range(7) == 0);
            ram_ready      = ($urandom_range(99) < 35);
            ram_rdata      = $urandom;
            cyc();
        end
        rst = 0;
        idle_in();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
